// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier back end: takes four pre-encoded
// single/double/negate digits and accumulates one shifted partial product per clock.
module booth_seq_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  y,
    input  logic [2:0]  sdn1,
    input  logic [2:0]  sdn2,
    input  logic [2:0]  sdn3,
    input  logic [2:0]  sdn4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       y_r;
    logic [3:0][2:0]  dig_r;
    logic [15:0]      acc;
    logic [1:0]       cnt;

    logic signed [9:0] pp;
    logic [15:0]       pp_ext;
    logic [15:0]       pp_shift;

    // Double wins over single, so the encoder-impossible 11x pattern acts as +/-2y.
    // A bare negate bit ("-0") leaves mag at zero and negating zero stays zero.
    function automatic logic signed [9:0] booth_pp(input logic [7:0] yv,
                                                    input logic [2:0] d);
        logic signed [9:0] mag;
        mag = '0;
        if (d[1])
            mag = {yv[7], yv, 1'b0};
        else if (d[2])
            mag = {{2{yv[7]}}, yv};
        return d[0] ? (~mag + 10'sd1) : mag;
    endfunction

    // NOTE: every combinational output is assigned unconditionally, so no latch can form.
    always_comb begin
        pp       = booth_pp(y_r, dig_r[cnt]);
        pp_ext   = {{6{pp[9]}}, pp};
        pp_shift = pp_ext << {cnt, 1'b0};
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values; the operand registers are reset too so an
    // aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            y_r   <= '0;
            dig_r <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        y_r   <= y;
                        dig_r <= {sdn4, sdn3, sdn2, sdn1};
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc + pp_shift;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign product   = acc;

endmodule
